motoro3_step_sequencer: RTL and testbench

- Upstream timing source for the three motoro3_pwm_generator instances (phases A/B/C).
- Divides time into 12 commutation steps (sgStep 0..11) of programmable length.
- Supplies the per-step down-counter m3cnt, the first/last strobes, the active and last-step flags, and the per-step PWM position demand pwmLENpos.
- Handles start, graceful stop at the end of an electrical cycle, and shadowing of its configuration registers.

---
 rtl/motoro3_pkg.sv | 25 ++
 rtl/motoro3_step_timer.sv | 52 +++++
 rtl/motoro3_step_sequencer.sv | 144 ++++++++++++++
 tb/tb_motoro3_step_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/motoro3_pkg.sv
// rtl/motoro3_pkg.sv - shared state encoding, step constants and strobe offsets for the motoro3 sequencer
package motoro3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        STOP  = 2'd3
    } seq_state_t;

    localparam int         STEP_NUM     = 12;
    localparam logic [3:0] STEP_LAST    = 4'(STEP_NUM - 1);
    localparam int         MIN_STEP_LEN = 8;

    localparam int FIRST2_OFS = 1;
    localparam int FIRST1_OFS = 2;
    localparam int LAST2_VAL  = 1;
    localparam int LAST1_VAL  = 0;

    // Final step of an electrical cycle for the given rotation direction.
    function automatic logic [3:0] dir_last_step(input logic rev, input logic [3:0] last);
        return rev ? 4'd0 : last;
    endfunction

endpackage

// File: rtl/motoro3_step_timer.sv
// rtl/motoro3_step_timer.sv - shadowed step length, m3cnt down-counter and the four step strobes
module motoro3_step_timer
    import motoro3_pkg::*;
#(
    parameter int CNT_W   = 25,
    parameter int MIN_LEN = 8
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             sample,
    input  logic             load,
    input  logic             active,
    input  logic             clear,
    input  logic [CNT_W-1:0] step_len,
    output logic [CNT_W-1:0] cnt,
    output logic             first2,
    output logic             first1,
    output logic             last2,
    output logic             last1
);

    localparam logic [CNT_W-1:0] MIN_L = CNT_W'(MIN_LEN);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] eff_len;

    assign eff_len = (step_len < MIN_L) ? MIN_L : step_len;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            shadow <= MIN_L;
            cnt    <= '0;
        end else begin
            if (sample || (active && last1))
                shadow <= eff_len;
            if (clear)
                cnt <= '0;
            else if (load)
                cnt <= shadow - ONE;
            else if (active)
                cnt <= last1 ? eff_len - ONE : cnt - ONE;
        end
    end

    // Decoded from registers only, so consumers sampling on negedge see stable values.
    assign first2 = active && (cnt == shadow - CNT_W'(FIRST2_OFS));
    assign first1 = active && (cnt == shadow - CNT_W'(FIRST1_OFS));
    assign last2  = active && (cnt == CNT_W'(LAST2_VAL));
    assign last1  = active && (cnt == CNT_W'(LAST1_VAL));

endmodule

// File: rtl/motoro3_step_sequencer.sv
// rtl/motoro3_step_sequencer.sv - 12-step commutation sequencer; MOTORO3_SEQ_DIR_EN adds reverse direction
module motoro3_step_sequencer #(
    parameter int STEP_NUM     = motoro3_pkg::STEP_NUM,
    parameter int CNT_W        = 25,
    parameter int MIN_STEP_LEN = motoro3_pkg::MIN_STEP_LEN
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             m3r_run,
`ifdef MOTORO3_SEQ_DIR_EN
    input  logic             m3r_dir,
`endif
    input  logic [CNT_W-1:0] m3r_stepLen,
    input  logic [15:0]      m3r_pwmLENpos,
    output logic [3:0]       sgStep,
    output logic [CNT_W-1:0] m3cnt,
    output logic             m3cntFirst2,
    output logic             m3cntFirst1,
    output logic             m3cntLast2,
    output logic             m3cntLast1,
    output logic             pwmActive1,
    output logic             pwmLastStep1,
    output logic [15:0]      pwmLENpos,
    output logic [15:0]      cycleCnt
);

    import motoro3_pkg::seq_state_t;
    import motoro3_pkg::IDLE;
    import motoro3_pkg::START;
    import motoro3_pkg::RUN;
    import motoro3_pkg::STOP;
    import motoro3_pkg::dir_last_step;

    localparam logic [3:0] LAST = 4'(STEP_NUM - 1);

    seq_state_t state;
    logic       stop_req;
    logic       dir_q;
    logic       dir_in;
    logic       active;
    logic       stop_now;
    logic       finish;
    logic       boundary;
    logic       dir_nxt;
    logic [3:0] step_nxt;

`ifdef MOTORO3_SEQ_DIR_EN
    assign dir_in = m3r_dir;
`else
    assign dir_in = 1'b0;
`endif

    assign active   = (state == RUN) || (state == STOP);
    assign stop_now = stop_req || !m3r_run;
    assign finish   = (state == STOP) && m3cntLast1;

    // Direction only changes when leaving the last step of the current order.
    always_comb begin
        boundary = (sgStep == dir_last_step(dir_q, LAST));
        dir_nxt  = boundary ? dir_in : dir_q;
        if (boundary)
            step_nxt = dir_nxt ? LAST : 4'd0;
        else if (dir_q)
            step_nxt = sgStep - 4'd1;
        else
            step_nxt = sgStep + 4'd1;
    end

    motoro3_step_timer #(
        .CNT_W   (CNT_W),
        .MIN_LEN (MIN_STEP_LEN)
    ) u_timer (
        .clk      (clk),
        .nRst     (nRst),
        .sample   ((state == IDLE) && m3r_run),
        .load     (state == START),
        .active   (active),
        .clear    (finish),
        .step_len (m3r_stepLen),
        .cnt      (m3cnt),
        .first2   (m3cntFirst2),
        .first1   (m3cntFirst1),
        .last2    (m3cntLast2),
        .last1    (m3cntLast1)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state        <= IDLE;
            sgStep       <= '0;
            pwmActive1   <= 1'b0;
            pwmLastStep1 <= 1'b0;
            pwmLENpos    <= '0;
            cycleCnt     <= '0;
            stop_req     <= 1'b0;
            dir_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    stop_req <= 1'b0;
                    if (m3r_run)
                        state <= START;
                end
                START: begin
                    sgStep     <= '0;
                    pwmLENpos  <= m3r_pwmLENpos;
                    cycleCnt   <= '0;
                    dir_q      <= dir_in;
                    pwmActive1 <= 1'b1;
                    state      <= RUN;
                end
                RUN: begin
                    if (!m3r_run)
                        stop_req <= 1'b1;
                    if (m3cntLast1) begin
                        sgStep    <= step_nxt;
                        pwmLENpos <= m3r_pwmLENpos;
                        dir_q     <= dir_nxt;
                        if (boundary && cycleCnt != 16'hFFFF)
                            cycleCnt <= cycleCnt + 16'd1;
                        if (stop_now && step_nxt == dir_last_step(dir_nxt, LAST)) begin
                            state        <= STOP;
                            pwmLastStep1 <= 1'b1;
                        end
                    end else if (stop_now && boundary) begin
                        state        <= STOP;
                        pwmLastStep1 <= 1'b1;
                    end
                end
                STOP: begin
                    if (m3cntLast1) begin
                        state        <= IDLE;
                        sgStep       <= '0;
                        pwmActive1   <= 1'b0;
                        pwmLastStep1 <= 1'b0;
                        stop_req     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// tb/tb_motoro3_step_sequencer.sv - scoreboard bench for motoro3_step_sequencer
module tb_motoro3_step_sequencer;

    logic        clk;
    logic        nRst;
    logic        run;
    logic [24:0] step_len;
    logic [15:0] len_pos;
`ifdef MOTORO3_SEQ_DIR_EN
    logic        dir;
`endif
    logic [3:0]  sgStep;
    logic [24:0] m3cnt;
    logic        m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1;
    logic        pwmActive1, pwmLastStep1;
    logic [15:0] pwmLENpos, cycleCnt;

    motoro3_step_sequencer dut (
        .clk           (clk),
        .nRst          (nRst),
        .m3r_run       (run),
`ifdef MOTORO3_SEQ_DIR_EN
        .m3r_dir       (dir),
`endif
        .m3r_stepLen   (step_len),
        .m3r_pwmLENpos (len_pos),
        .sgStep        (sgStep),
        .m3cnt         (m3cnt),
        .m3cntFirst2   (m3cntFirst2),
        .m3cntFirst1   (m3cntFirst1),
        .m3cntLast2    (m3cntLast2),
        .m3cntLast1    (m3cntLast1),
        .pwmActive1    (pwmActive1),
        .pwmLastStep1  (pwmLastStep1),
        .pwmLENpos     (pwmLENpos),
        .cycleCnt      (cycleCnt)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    typedef struct {
        int step;
        int len;
        int lp;
        bit last;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input int s, input int l, input int p, input bit la, input int c);
        q.push_back('{s, l, p, la, c});
    endtask

    task automatic wait_step(input int s, input int c);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(pwmActive1 && 32'(sgStep) == s && (c < 0 || 32'(cycleCnt) == c)) && n < 3000);
        if (n >= 3000) chk("wait_step_timeout", 32'(n), 32'(2999));
    endtask

    task automatic wait_last(input int s);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(m3cntLast1 && 32'(sgStep) == s) && n < 3000);
        if (n >= 3000) chk("wait_last_timeout", 32'(n), 32'(2999));
    endtask

    task automatic check_stopped(input string tag);
        chk({tag, "_active_at_last1"}, 32'(pwmActive1), 32'(1));
        @(negedge clk);
        chk({tag, "_active_after"}, 32'(pwmActive1), 32'(0));
        chk({tag, "_step_after"}, 32'(sgStep), 32'(0));
        chk({tag, "_cnt_after"}, 32'(m3cnt), 32'(0));
        chk({tag, "_laststep_after"}, 32'(pwmLastStep1), 32'(0));
    endtask

    // Monitor: tracks each step from First2 to Last1 and pops the scoreboard at Last1.
    int   pos = 0;
    bit   in_step = 0, has_cur = 0, ok_s = 1, ok_f = 1;
    exp_t cur;

    always @(negedge clk) begin
        if (!nRst) begin
            in_step = 0;
        end else begin
            if (m3cntFirst2) begin
                chk("step_overlap", 32'(in_step), 32'(0));
                in_step = 1;
                pos     = 0;
                has_cur = (q.size() > 0);
                if (has_cur) cur = q[0];
                ok_s = 1;
                ok_f = 1;
            end else if (in_step) begin
                pos++;
            end else begin
                chk("stray_strobe", 32'({m3cntFirst1, m3cntLast2, m3cntLast1}), 32'(0));
            end
            if (in_step && has_cur) begin
                if (!((m3cntFirst2 === (pos == 0)) && (m3cntFirst1 === (pos == 1)) &&
                      (m3cntLast2 === (pos == cur.len - 2)) && (m3cntLast1 === (pos == cur.len - 1)) &&
                      (32'(m3cnt) === 32'(cur.len - 1 - pos))))
                    ok_s = 0;
                if (!((pwmActive1 === 1'b1) && (32'(sgStep) === 32'(cur.step)) &&
                      (32'(pwmLENpos) === 32'(cur.lp)) && (pwmLastStep1 === cur.last)))
                    ok_f = 0;
            end
            if (in_step && m3cntLast1) begin
                chk("step_expected", 32'(has_cur), 32'(1));
                if (has_cur) begin
                    void'(q.pop_front());
                    chk("step_index", 32'(sgStep), 32'(cur.step));
                    chk("step_period", 32'(pos + 1), 32'(cur.len));
                    chk("strobe_pattern", 32'(ok_s), 32'(1));
                    chk("step_outputs", 32'(ok_f), 32'(1));
                    if (cur.cyc >= 0) chk("cycle_cnt", 32'(cycleCnt), 32'(cur.cyc));
                end
                in_step = 0;
            end
        end
    end

    initial begin
        #6000000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1);
    end

    initial begin
        int n;
        nRst     = 1'b0;
        run      = 1'b0;
        step_len = 25'd20;
        len_pos  = 16'h0100;
`ifdef MOTORO3_SEQ_DIR_EN
        dir      = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_step", 32'(sgStep), 32'(0));
        chk("reset_cnt", 32'(m3cnt), 32'(0));
        chk("reset_strobes", 32'({m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1}), 32'(0));
        chk("reset_active", 32'(pwmActive1), 32'(0));
        chk("reset_laststep", 32'(pwmLastStep1), 32'(0));
        chk("reset_lenpos", 32'(pwmLENpos), 32'(0));
        chk("reset_cycles", 32'(cycleCnt), 32'(0));
        nRst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_active", 32'(pwmActive1), 32'(0));

        // Timing, shadowing, clamp and graceful stop in one continuous run.
        for (int s = 0; s < 12; s++) push(s, 20, 'h100, 0, 0);
        for (int s = 0; s < 5; s++)  push(s, 20, 'h100, 0, 1);
        for (int s = 5; s < 8; s++)  push(s, 40, 'h200, 0, 1);
        for (int s = 8; s < 12; s++) push(s, 8, 'h300, 0, 1);
        for (int s = 0; s < 11; s++) push(s, 8, 'h300, 0, 2);
        push(11, 8, 'h300, 1, 2);
        run = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!pwmActive1 && n < 50);
        chk("first_run_first2", 32'(m3cntFirst2), 32'(1));
        chk("first_run_cnt", 32'(m3cnt), 32'(19));
        chk("first_run_lenpos", 32'(pwmLENpos), 32'h100);
        wait_step(4, 1);
        repeat (5) @(negedge clk);
        step_len = 25'd40;
        len_pos  = 16'h0200;
        wait_step(7, 1);
        repeat (5) @(negedge clk);
        step_len = 25'd3;
        len_pos  = 16'h0300;
        wait_step(3, 2);
        run = 1'b0;
        wait_last(11);
        check_stopped("stop");

        // One-clock low glitch on run still ends the sequence after step 11.
        step_len = 25'd12;
        len_pos  = 16'h0400;
        for (int s = 0; s < 11; s++) push(s, 12, 'h400, 0, 0);
        push(11, 12, 'h400, 1, 0);
        run = 1'b1;
        wait_step(2, 0);
        run = 1'b0;
        @(negedge clk);
        run = 1'b1;
        wait_last(11);
        run = 1'b0;
        check_stopped("glitch");

        // Asynchronous reset in step 7, then a clean restart from step 0.
        step_len = 25'd20;
        len_pos  = 16'h0500;
        for (int s = 0; s < 7; s++) push(s, 20, 'h500, 0, 0);
        run = 1'b1;
        wait_step(7, 0);
        repeat (3) @(negedge clk);
        nRst = 1'b0;
        #1;
        chk("async_reset_step", 32'(sgStep), 32'(0));
        chk("async_reset_cnt", 32'(m3cnt), 32'(0));
        chk("async_reset_active", 32'(pwmActive1), 32'(0));
        chk("async_reset_lenpos", 32'(pwmLENpos), 32'(0));
        chk("async_reset_strobes", 32'({m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1}), 32'(0));
        @(negedge clk);
        nRst = 1'b1;
        for (int s = 0; s < 11; s++) push(s, 20, 'h500, 0, 0);
        push(11, 20, 'h500, 1, 0);
        wait_step(1, 0);
        run = 1'b0;
        wait_last(11);
        check_stopped("restart");

`ifdef MOTORO3_SEQ_DIR_EN
        // Reverse order: 0, 11 .. 1, then the final step 0 is flagged.
        dir      = 1'b1;
        step_len = 25'd8;
        len_pos  = 16'h0600;
        push(0, 8, 'h600, 0, -1);
        for (int s = 11; s >= 1; s--) push(s, 8, 'h600, 0, -1);
        push(0, 8, 'h600, 1, -1);
        run = 1'b1;
        wait_step(3, -1);
        run = 1'b0;
        wait_last(0);
        check_stopped("reverse");
        dir = 1'b0;
`endif

        n = 0;
        while (q.size() != 0 && n < 500) begin @(negedge clk); n++; end
        chk("queue_drained", 32'(q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
